// File: rtl/conv_para_sched.sv
// conv_para_sched
//   Sequences one convolution job over num_ch input channels. For every
//   channel pass it issues ks*ks weight/feature reads, releases the
//   convolution unit from reset one cycle after the first read, waits for
//   the unit's result tile and presents it downstream with a valid/ready
//   handshake. A watchdog aborts the job if the unit never answers.
//
// Ports
//   clk, rst            : rising-edge clock, asynchronous active-low reset
//   start               : job request pulse (ignored while busy)
//   kernel_size         : 3 or 5; anything else rejects the job with err
//   num_ch              : input channel count; 0 completes immediately
//   wt_base             : weight base address of the job
//   busy, done, err     : job in progress, one-cycle end pulse, sticky error
//   rd_en, wt_addr      : read strobe and weight address
//   fm_ch, fm_step      : feature channel and window step of the read
//   conv_rst, conv_ks   : active-low reset and kernel size to the conv unit
//   conv_result_ready,
//   conv_result         : result strobe and tile from the conv unit
//   out_valid, out_ready,
//   out_data, out_ch    : captured tile and its channel, downstream handshake
module conv_para_sched #(
    parameter int DATA_WIDTH        = 16,
    parameter int PARA_X            = 4,
    parameter int PARA_Y            = 4,
    parameter int KERNEL_SIZE_WIDTH = 4,
    parameter int CH_WIDTH          = 10,
    parameter int WADDR_WIDTH       = 16,
    parameter int WAIT_MAX          = 64
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [KERNEL_SIZE_WIDTH-1:0]            kernel_size,
    input  logic [CH_WIDTH-1:0]                     num_ch,
    input  logic [WADDR_WIDTH-1:0]                  wt_base,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err,
    output logic                                    rd_en,
    output logic [WADDR_WIDTH-1:0]                  wt_addr,
    output logic [CH_WIDTH-1:0]                     fm_ch,
    output logic [2*KERNEL_SIZE_WIDTH-1:0]          fm_step,
    output logic                                    conv_rst,
    output logic [KERNEL_SIZE_WIDTH-1:0]            conv_ks,
    input  logic                                    conv_result_ready,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]     conv_result,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]     out_data,
    output logic [CH_WIDTH-1:0]                     out_ch
);

    localparam int TILE_W = PARA_X * PARA_Y * DATA_WIDTH;
    localparam int STEP_W = 2 * KERNEL_SIZE_WIDTH;
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_t;

    state_t                       state_q, state_d;
    logic [CH_WIDTH-1:0]          ch_q, ch_d;
    logic [CH_WIDTH-1:0]          num_ch_q, num_ch_d;
    logic [STEP_W-1:0]            k_q, k_d;
    logic [WCNT_W-1:0]            wcnt_q, wcnt_d;

    logic                         busy_d, done_d, err_d, rd_en_d;
    logic [WADDR_WIDTH-1:0]       wt_addr_d;
    logic [CH_WIDTH-1:0]          fm_ch_d;
    logic [STEP_W-1:0]            fm_step_d;
    logic                         conv_rst_d;
    logic [KERNEL_SIZE_WIDTH-1:0] conv_ks_d;
    logic                         out_valid_d;
    logic [TILE_W-1:0]            out_data_d;
    logic [CH_WIDTH-1:0]          out_ch_d;

    logic [STEP_W-1:0]            kk;
    logic                         ks_legal;

    // Steps per pass, from the kernel size latched for this job
    assign kk       = STEP_W'(conv_ks) * STEP_W'(conv_ks);
    assign ks_legal = (kernel_size == KERNEL_SIZE_WIDTH'(3)) ||
                      (kernel_size == KERNEL_SIZE_WIDTH'(5));

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        num_ch_d    = num_ch_q;
        k_d         = k_q;
        wcnt_d      = wcnt_q;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;
        rd_en_d     = rd_en;
        wt_addr_d   = wt_addr;
        fm_ch_d     = fm_ch;
        fm_step_d   = fm_step;
        conv_rst_d  = conv_rst;
        conv_ks_d   = conv_ks;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_ch_d    = out_ch;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!ks_legal) begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end else if (num_ch == '0) begin
                        err_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        conv_ks_d = kernel_size;
                        num_ch_d  = num_ch;
                        err_d     = 1'b0;
                        ch_d      = '0;
                        k_d       = '0;
                        wt_addr_d = wt_base;
                        fm_ch_d   = '0;
                        fm_step_d = '0;
                        rd_en_d   = 1'b1;
                        busy_d    = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end

            ISSUE: begin
                // Data for step 0 lands one cycle after its read, so the
                // unit leaves reset on the edge closing the first read.
                if (k_q == '0) begin
                    conv_rst_d = 1'b1;
                end
                if (k_q == kk - STEP_W'(1)) begin
                    rd_en_d = 1'b0;
                    wcnt_d  = '0;
                    state_d = WAIT;
                end else begin
                    k_d       = k_q + STEP_W'(1);
                    fm_step_d = k_q + STEP_W'(1);
                    wt_addr_d = wt_addr + WADDR_WIDTH'(1);
                end
            end

            WAIT: begin
                if (conv_result_ready) begin
                    out_data_d  = conv_result;
                    out_ch_d    = ch_q;
                    conv_rst_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = OUT;
                end else if (wcnt_q == WCNT_W'(WAIT_MAX - 1)) begin
                    err_d      = 1'b1;
                    conv_rst_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end

            OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (ch_q == num_ch_q - CH_WIDTH'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        ch_d      = ch_q + CH_WIDTH'(1);
                        fm_ch_d   = ch_q + CH_WIDTH'(1);
                        k_d       = '0;
                        fm_step_d = '0;
                        // Passes are contiguous: the last address of the
                        // previous pass is still held, so the next pass
                        // starts one above it (wt_base + ch*ks*ks).
                        wt_addr_d = wt_addr + WADDR_WIDTH'(1);
                        rd_en_d   = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            num_ch_q  <= '0;
            k_q       <= '0;
            wcnt_q    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_en     <= 1'b0;
            wt_addr   <= '0;
            fm_ch     <= '0;
            fm_step   <= '0;
            conv_rst  <= 1'b0;
            conv_ks   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            num_ch_q  <= num_ch_d;
            k_q       <= k_d;
            wcnt_q    <= wcnt_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
            rd_en     <= rd_en_d;
            wt_addr   <= wt_addr_d;
            fm_ch     <= fm_ch_d;
            fm_step   <= fm_step_d;
            conv_rst  <= conv_rst_d;
            conv_ks   <= conv_ks_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_ch    <= out_ch_d;
        end
    end

endmodule

// File: tb/tb_conv_para_sched.sv
// tb_conv_para_sched
//   Table of jobs applied in a loop; expected read issues and result tiles
//   are queued when stimulus is driven and popped as the design produces
//   them. Hand-written sequences cover mid-job reset.
module tb_conv_para_sched;

    localparam int DW   = 16;
    localparam int PX   = 4;
    localparam int PY   = 4;
    localparam int KSW  = 4;
    localparam int CHW  = 10;
    localparam int AW   = 16;
    localparam int WMAX = 64;
    localparam int TW   = PX * PY * DW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [KSW-1:0]  kernel_size = '0;
    logic [CHW-1:0]  num_ch = '0;
    logic [AW-1:0]   wt_base = '0;
    logic            busy, done, err, rd_en;
    logic [AW-1:0]   wt_addr;
    logic [CHW-1:0]  fm_ch;
    logic [2*KSW-1:0] fm_step;
    logic            conv_rst;
    logic [KSW-1:0]  conv_ks;
    logic            conv_result_ready = 1'b0;
    logic [TW-1:0]   conv_result = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [TW-1:0]   out_data;
    logic [CHW-1:0]  out_ch;

    always #5 clk = ~clk;

    conv_para_sched #(
        .DATA_WIDTH(DW),
        .PARA_X(PX),
        .PARA_Y(PY),
        .KERNEL_SIZE_WIDTH(KSW),
        .CH_WIDTH(CHW),
        .WADDR_WIDTH(AW),
        .WAIT_MAX(WMAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .kernel_size(kernel_size),
        .num_ch(num_ch),
        .wt_base(wt_base),
        .busy(busy),
        .done(done),
        .err(err),
        .rd_en(rd_en),
        .wt_addr(wt_addr),
        .fm_ch(fm_ch),
        .fm_step(fm_step),
        .conv_rst(conv_rst),
        .conv_ks(conv_ks),
        .conv_result_ready(conv_result_ready),
        .conv_result(conv_result),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_ch(out_ch)
    );

    typedef struct {
        logic [AW-1:0]    addr;
        logic [CHW-1:0]   ch;
        logic [2*KSW-1:0] step;
    } issue_t;

    typedef struct {
        logic [TW-1:0]  data;
        logic [CHW-1:0] ch;
    } tile_t;

    typedef struct {
        int ks;
        int nch;
        int base;
        int rdly;   // cycles in WAIT before the result strobe
        int adly;   // cycles out_ready is held low in OUT
        bit tmo;    // never answer: watchdog expected
    } job_t;

    issue_t iss_q[$];
    tile_t  tile_q[$];
    job_t   jobs[7];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] rand_tile();
        logic [TW-1:0] t;
        t = '0;
        for (int i = 0; i < TW / 32; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    task automatic run_job(input job_t j);
        int     kk;
        bit     legal;
        issue_t it;
        tile_t  tt;
        kk    = j.ks * j.ks;
        legal = (j.ks == 3) || (j.ks == 5);
        @(negedge clk);
        start       = 1'b1;
        kernel_size = KSW'(j.ks);
        num_ch      = CHW'(j.nch);
        wt_base     = AW'(j.base);
        if (legal) begin
            for (int c = 0; c < j.nch; c++) begin
                for (int k = 0; k < kk; k++) begin
                    it.addr = AW'(j.base + c * kk + k);
                    it.ch   = CHW'(c);
                    it.step = (2*KSW)'(k);
                    iss_q.push_back(it);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;

        if (!legal || j.nch == 0) begin
            chk("rej_done", done, 1);
            chk("rej_err", err, legal ? 0 : 1);
            chk("rej_busy", busy, 0);
            chk("rej_rd_en", rd_en, 0);
            @(negedge clk);
            chk("rej_done_pulse", done, 0);
            chk("rej_err_sticky", err, legal ? 0 : 1);
            chk("rej_rd_en2", rd_en, 0);
            return;
        end

        chk("start_err_clr", err, 0);
        for (int c = 0; c < j.nch; c++) begin
            for (int k = 0; k < kk; k++) begin
                chk("iss_rd_en", rd_en, 1);
                chk("iss_busy", busy, 1);
                chk("iss_done", done, 0);
                chk("iss_conv_ks", conv_ks, j.ks);
                chk("iss_conv_rst", conv_rst, (k == 0) ? 0 : 1);
                if (iss_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL iss_queue: got extra read, expected none");
                end else begin
                    it = iss_q.pop_front();
                    chk("wt_addr", wt_addr, it.addr);
                    chk("fm_ch", fm_ch, it.ch);
                    chk("fm_step", fm_step, it.step);
                end
                @(negedge clk);
            end

            chk("wait_rd_en", rd_en, 0);
            chk("wait_conv_rst", conv_rst, 1);
            chk("wait_busy", busy, 1);

            if (j.tmo) begin
                for (int i = 1; i < WMAX; i++) begin
                    @(negedge clk);
                    chk("wd_early_done", done, 0);
                end
                @(negedge clk);
                chk("wd_done", done, 1);
                chk("wd_err", err, 1);
                chk("wd_conv_rst", conv_rst, 0);
                chk("wd_busy", busy, 0);
                @(negedge clk);
                chk("wd_done_pulse", done, 0);
                chk("wd_err_sticky", err, 1);
                return;
            end

            for (int d = 0; d < j.rdly; d++) begin
                chk("wait_out_valid", out_valid, 0);
                @(negedge clk);
            end
            tt.data = rand_tile();
            tt.ch   = CHW'(c);
            tile_q.push_back(tt);
            conv_result_ready = 1'b1;
            conv_result       = tt.data;
            @(negedge clk);
            conv_result_ready = 1'b0;
            conv_result       = rand_tile();
            chk("out_valid", out_valid, 1);
            chk("out_conv_rst", conv_rst, 0);
            chk("out_rd_en", rd_en, 0);

            // Held off: late strobe and a start while busy must both be ignored
            for (int h = 0; h < j.adly; h++) begin
                start             = (h == 0);
                conv_result_ready = (h == 0);
                kernel_size       = KSW'(5);
                num_ch            = CHW'(1);
                wt_base           = AW'(16'h2222);
                @(negedge clk);
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, tile_q[0].data);
                chk("hold_rd_en", rd_en, 0);
                chk("hold_err", err, 0);
            end
            start             = 1'b0;
            conv_result_ready = 1'b0;

            out_ready = 1'b1;
            tt = tile_q.pop_front();
            chk("acc_valid", out_valid, 1);
            chk("out_data", out_data, tt.data);
            chk("out_ch", out_ch, tt.ch);
            @(negedge clk);
            out_ready = 1'b0;
            chk("post_acc_valid", out_valid, 0);
            if (c == j.nch - 1) begin
                chk("job_done", done, 1);
                chk("job_busy", busy, 0);
                chk("job_err", err, 0);
                @(negedge clk);
                chk("job_done_pulse", done, 0);
            end else begin
                chk("mid_done", done, 0);
            end
        end
    endtask

    initial begin
        //         ks nch  base     rdly adly tmo
        jobs[0] = '{3, 1, 'h100,  2,  0, 1'b0};
        jobs[1] = '{5, 3, 0,      3,  1, 1'b0};
        jobs[2] = '{3, 2, 'hFFFA, 0, 10, 1'b0};
        jobs[3] = '{4, 2, 'h10,   0,  0, 1'b0};
        jobs[4] = '{3, 0, 'h20,   0,  0, 1'b0};
        jobs[5] = '{5, 1, 'h300,  0,  0, 1'b1};
        jobs[6] = '{3, 1, 'h40,   1,  2, 1'b0};

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_conv_rst", conv_rst, 0);
        chk("rst_wt_addr", wt_addr, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (jobs[i]) run_job(jobs[i]);

        // Mid-ISSUE asynchronous reset
        @(negedge clk);
        start       = 1'b1;
        kernel_size = KSW'(3);
        num_ch      = CHW'(2);
        wt_base     = AW'(16'h40);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_rd_en", rd_en, 1);
        chk("pre_rst_wt_addr", wt_addr, 16'h43);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_conv_rst", conv_rst, 0);
        chk("arst_wt_addr", wt_addr, 0);
        chk("arst_fm_ch", fm_ch, 0);
        chk("arst_fm_step", fm_step, 0);
        chk("arst_out_ch", out_ch, 0);
        chk("arst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end

        run_job('{5, 2, 'h500, 1, 1, 1'b0});

        checks++;
        if (iss_q.size() != 0 || tile_q.size() != 0) begin
            failures++;
            $display("FAIL queues_drained: got %0d/%0d entries left, expected 0/0", iss_q.size(), tile_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_para_sched.md
CONV_PARA_SCHED -- requirements
Module: conv_para_sched

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 16, float16 element width
- PARA_X, 4, output tile rows
- PARA_Y, 4, output tile columns
- KERNEL_SIZE_WIDTH, 4, kernel size field width
- CH_WIDTH, 10, channel index width
- WADDR_WIDTH, 16, weight memory address width
- WAIT_MAX, 64, watchdog limit in cycles
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-low reset (0: reset; 1: none)
- start, in, 1, job request pulse
- kernel_size, in, KERNEL_SIZE_WIDTH, 3 or 5
- num_ch, in, CH_WIDTH, input channel count
- wt_base, in, WADDR_WIDTH, weight base address
- busy, out, 1, job in progress
- done, out, 1, one-cycle job-end pulse
- err, out, 1, sticky job error
- rd_en, out, 1, weight/feature read strobe
- wt_addr, out, WADDR_WIDTH, weight read address
- fm_ch, out, CH_WIDTH, feature channel index
- fm_step, out, 2*KERNEL_SIZE_WIDTH, window step index
- conv_rst, out, 1, active-low reset to the convolution unit
- conv_ks, out, KERNEL_SIZE_WIDTH, latched kernel size
- conv_result_ready, in, 1, convolution unit result strobe
- conv_result, in, PARA_X*PARA_Y*DATA_WIDTH, convolution unit tile
- out_valid, out, 1, tile available
- out_ready, in, 1, downstream accept
- out_data, out, PARA_X*PARA_Y*DATA_WIDTH, captured tile
- out_ch, out, CH_WIDTH, channel of out_data

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, OUT; all outputs SHALL be registered.
REQ-004 IDLE: busy=0; start with kernel_size in {3,5} and num_ch>0 SHALL latch kernel_size, num_ch and wt_base, clear err, set ch=0, k=0, and enter ISSUE on the next edge.
REQ-005 IDLE, start with an illegal kernel_size: the block SHALL set err=1, pulse done for one cycle, and stay in IDLE; start with num_ch=0 SHALL pulse done with err=0.
REQ-006 start while busy=1 SHALL be ignored.
REQ-007 ISSUE SHALL last exactly ks*ks cycles, k=0..ks*ks-1, with rd_en=1, fm_ch=ch, fm_step=k, and wt_addr=wt_base+ch*ks*ks+k (modulo 2^WADDR_WIDTH), then enter WAIT.
REQ-008 Read latency is one cycle; conv_rst SHALL go 1 on the edge ending the first ISSUE cycle of each channel pass, so the unit samples step k one cycle after its issue.
REQ-009 WAIT: rd_en=0; conv_result_ready=1 SHALL capture conv_result into out_data and ch into out_ch, drive conv_rst=0, set out_valid=1, and enter OUT.
REQ-010 WAIT watchdog: a counter cleared on WAIT entry; reaching WAIT_MAX without conv_result_ready SHALL set err=1, drive conv_rst=0, pulse done, and enter IDLE.
REQ-011 OUT: out_valid and out_data SHALL hold stable until out_valid&&out_ready; on that handshake out_valid=0 and:
- if ch==num_ch-1: pulse done and enter IDLE
- else: ch=ch+1, k=0, enter ISSUE
REQ-012 conv_result_ready outside WAIT SHALL be ignored; conv_ks SHALL equal the latched kernel_size for the whole job.
REQ-013 busy SHALL be 1 in ISSUE, WAIT and OUT.

Reset
REQ-014 rst=0 SHALL asynchronously force IDLE with busy, done, err, rd_en, out_valid and conv_rst all 0, wt_addr, fm_ch, fm_step, out_ch and out_data all 0, and the counters cleared; this SHALL apply mid-job with no pending done.

Verification
REQ-015 ks=3, num_ch=1, wt_base=0x100: wt_addr 0x100..0x108 over 9 ISSUE cycles; conv_rst rises 1 cycle after the first issue; capture on the result strobe; done 1 cycle after the out handshake.
REQ-016 ks=5, num_ch=3, wt_base=0: the third pass issues wt_addr 50..74; out_ch reads 0,1,2; exactly one done pulse.
REQ-017 out_ready held 0 for 10 cycles in OUT: out_valid and out_data stable, no new ISSUE until accept.
REQ-018 conv_result_ready never asserted: err=1, done pulse and conv_rst=0 exactly WAIT_MAX cycles after WAIT entry.
REQ-019 start with ks=4 -> err=1 and a done pulse with no rd_en; rst=0 asserted mid-ISSUE -> all outputs 0 immediately, the next start runs normally.
